inst_fetch_queue: RTL and testbench

Instruction fetch front end for the single-cycle ARM-subset core. It generates word addresses into the synchronous code memory, which has 1-cycle read latency. Returned instruction words are tagged with their PC and buffered in a small prefetch FIFO. The decode/execute stage consumes them over a valid/ready handshake. Branch redirects from execute flush the queue and any in-flight read, then restart fetch at the target.

---
 rtl/inst_fetch_queue_pkg.sv | 17 +
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fetch_queue_fifo.sv | 42 ++++
 rtl/inst_fetch_queue.sv | 94 +++++++++
 tb/tb_inst_fetch_queue.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;
  localparam int INST_W     = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_FLUSH} fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Word index of a byte PC; the caller truncates it to the code memory width.
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return pc >> $clog2(WORD_BYTES);
  endfunction
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch queue bus: code memory port, branch redirect and decode-side handshake.
interface inst_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int CODE_ADDR_W = 3
);
  logic                   imem_en;
  logic [CODE_ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0]      imem_rdata;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [INST_W-1:0]      out_inst;
  logic [31:0]            out_pc;
  logic [31:0]            fetch_pc;

  modport master (
    output imem_en, imem_addr, out_valid, out_inst, out_pc, fetch_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, out_inst, out_pc, fetch_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Prefetch FIFO of {pc, inst} entries; reset beats flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: credit-limited code memory reads into a prefetch FIFO.
// Build option FETCH_BYPASS_EN presents a response straight to out_* when the FIFO is empty.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          CODE_ADDR_W = 3,
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  localparam int         CW          = $clog2(DEPTH) + 1
) (
  input logic                 clk,
  input logic                 nreset,
  inst_fetch_queue_if.master  bus
);
  fetch_state_e  state, state_nxt;
  logic [31:0]   fetch_pc, rsp_pc;
  logic          inflight;
  logic          issue, drop_rsp, rsp_live, bypass, push, pop;
  logic [CW-1:0] count;
  fetch_entry_t  head;

  // One read in flight is counted as a reserved slot, so a response never finds the FIFO full.
  assign issue = !nreset && !bus.redirect_valid &&
                 ((32'(count) + 32'(inflight)) < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (nreset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & ~32'h3;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'(WORD_BYTES);
        rsp_pc   <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) state <= ST_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RESET: state_nxt = bus.redirect_valid ? ST_FLUSH : ST_RUN;
      ST_RUN:   state_nxt = bus.redirect_valid ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_nxt = bus.redirect_valid ? ST_FLUSH : ST_RUN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // Responses are only trusted in RUN with no redirect pending; elsewhere they are stale.
  always_comb begin
    drop_rsp = 1'b1;
    unique case (state)
      ST_RUN:  drop_rsp = bus.redirect_valid;
      default: drop_rsp = 1'b1;
    endcase
  end

  assign rsp_live = inflight && !drop_rsp;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_live && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign pop  = !nreset && (count != '0) && bus.out_ready;
  assign push = rsp_live && !(bypass && bus.out_ready);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .din    ('{pc: rsp_pc, inst: bus.imem_rdata}),
    .pop    (pop),
    .flush  (bus.redirect_valid),
    .count  (count),
    .head   (head)
  );

  assign bus.imem_en   = issue;
  assign bus.imem_addr = CODE_ADDR_W'(word_addr(fetch_pc));
  assign bus.fetch_pc  = fetch_pc;
  assign bus.out_valid = !nreset && ((count != '0) || bypass);
  assign bus.out_inst  = bypass ? bus.imem_rdata : head.inst;
  assign bus.out_pc    = bypass ? rsp_pc : head.pc;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an 8-word synchronous code memory model.
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic nreset;
  int   checks = 0;
  int   errors = 0;
  int   en_cnt;
  logic [31:0] mem [8];

  inst_fetch_queue_if #(.CODE_ADDR_W(3)) bus ();

  inst_fetch_queue #(.CODE_ADDR_W(3), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Leaves the DUT in cycle 0 (first cycle out of reset) with out_ready low.
  task automatic do_reset();
    nreset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'hE3A0_2007 + 32'(i << 12);
    nreset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (3) step();
    chk("rst_imem_en",   32'(bus.imem_en),   0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_inst",  bus.out_inst,       0);
    chk("rst_out_pc",    bus.out_pc,         0);
    chk("rst_fetch_pc",  bus.fetch_pc,       0);

    // Streaming: one instruction per cycle from cycle 2, address wraps 7->0
    nreset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("s_imem_en0",  32'(bus.imem_en), 1);
    chk("s_imem_addr0", 32'(bus.imem_addr), 0);
    step();
    chk("s_latency", 32'(bus.out_valid), 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("s_valid", 32'(bus.out_valid), 1);
      chk("s_pc",    bus.out_pc,   32'(4 * k));
      chk("s_inst",  bus.out_inst, mem[k % 8]);
      chk("s_addr",  32'(bus.imem_addr), 32'((k + 2) % 8));
    end

    // Backpressure: exactly DEPTH reads issued, then in-order drain
    do_reset();
    en_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      en_cnt += int'(bus.imem_en);
      step();
    end
    chk("bp_issued", 32'(en_cnt), 4);
    chk("bp_en_full", 32'(bus.imem_en), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_pc",    bus.out_pc,   32'(4 * k));
      chk("bp_inst",  bus.out_inst, mem[k]);
      step();
    end

    // Redirect with 8,12,16 queued and 20 in flight
    do_reset();
    repeat (10) step();
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    step();
    chk("rd_head_pc", bus.out_pc, 32'h8);
    chk("rd_en_full", 32'(bus.imem_en), 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4;
    #1;
    chk("rd_en_r", 32'(bus.imem_en), 0);
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    #1;
    chk("rd_valid_r1", 32'(bus.out_valid), 0);
    chk("rd_fetch_pc", bus.fetch_pc, 32'h4);
    chk("rd_en_r1",    32'(bus.imem_en), 1);
    chk("rd_addr_r1",  32'(bus.imem_addr), 1);
    step();
    chk("rd_valid_r2", 32'(bus.out_valid), 0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("rd_valid", 32'(bus.out_valid), 1);
      chk("rd_pc",    bus.out_pc,   32'(4 * k));
      chk("rd_inst",  bus.out_inst, mem[k]);
    end

    // Unaligned target then a back-to-back redirect: only the last one fetched
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_000B;
    #1;
    chk("bb_en_r1", 32'(bus.imem_en), 0);
    step();
    chk("bb_align", bus.fetch_pc, 32'h8);
    bus.redirect_pc = 32'h0000_0014;
    #1;
    chk("bb_en_r2", 32'(bus.imem_en), 0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("bb_fetch_pc", bus.fetch_pc, 32'h14);
    chk("bb_addr",     32'(bus.imem_addr), 5);
    chk("bb_valid0",   32'(bus.out_valid), 0);
    step();
    chk("bb_valid1", 32'(bus.out_valid), 0);
    step();
    chk("bb_valid2", 32'(bus.out_valid), 1);
    chk("bb_pc",     bus.out_pc,   32'h14);
    chk("bb_inst",   bus.out_inst, mem[5]);
    step();
    chk("bb_pc_next",   bus.out_pc,   32'h18);
    chk("bb_inst_next", bus.out_inst, mem[6]);

    // One-cycle reset with 3 entries queued and PC 12 in flight
    do_reset();
    repeat (4) step();
    chk("mr_valid_pre", 32'(bus.out_valid), 1);
    nreset = 1'b1;
    #1;
    chk("mr_en_rst",    32'(bus.imem_en), 0);
    chk("mr_valid_rst", 32'(bus.out_valid), 0);
    step();
    nreset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("mr_valid0",   32'(bus.out_valid), 0);
    chk("mr_fetch_pc", bus.fetch_pc, 32'h0);
    chk("mr_out_pc",   bus.out_pc,   32'h0);
    chk("mr_en",       32'(bus.imem_en), 1);
    step();
    chk("mr_valid1", 32'(bus.out_valid), 0);
    step();
    chk("mr_valid2", 32'(bus.out_valid), 1);
    chk("mr_pc0",    bus.out_pc,   32'h0);
    chk("mr_inst0",  bus.out_inst, mem[0]);
    step();
    chk("mr_pc1",    bus.out_pc,   32'h4);
    chk("mr_inst1",  bus.out_inst, mem[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
